me_pixel_feeder: RTL

// - Pixel source answering the motion-estimation controller's read requests (en_ram/addr/amt).
// - Buffers one SEARCH_DIMxSEARCH_DIM search window and one MACRO_DIMxMACRO_DIM current macroblock,

---
 rtl/me_pkg.sv | 20 ++
 rtl/me_pixel_feeder_if.sv | 31 +++
 rtl/me_row_window.sv | 30 +++
 rtl/me_pixel_feeder.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// Shared types and defaults for the motion-estimation pixel feeder.
//   pixel_t        : one 8-bit luma sample
//   feeder_state_t : feeder load/serve FSM states
package me_pkg;

  localparam int unsigned MACRO_DIM_DEF  = 16;
  localparam int unsigned SEARCH_DIM_DEF = 48;
  localparam int unsigned SEGS           = SEARCH_DIM_DEF / MACRO_DIM_DEF;
  localparam int unsigned ADDR_W         = 6;

  typedef logic [7:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_SPR,
    LOAD_CPR,
    SERVE
  } feeder_state_t;

endpackage

// File: rtl/me_pixel_feeder_if.sv
// Load stream and read port of the pixel feeder.
//   master : loader / controller side (drives load beats and read requests)
//   slave  : feeder side (drives wr_ready, loaded and the pixel rows)
interface me_pixel_feeder_if
  import me_pkg::*;
#(
  parameter int unsigned MACRO_DIM = MACRO_DIM_DEF
) ();

  logic                    load_start;
  logic                    wr_valid;
  logic                    wr_ready;
  pixel_t [MACRO_DIM-1:0]  wr_data;
  logic                    loaded;
  logic                    en_ram;
  logic [ADDR_W-1:0]       addr;
  logic [ADDR_W-1:0]       amt;
  pixel_t [MACRO_DIM:0]    pixel_spr_out;
  pixel_t [MACRO_DIM-1:0]  pixel_cpr_out;

  modport master (
    output load_start, wr_valid, wr_data, en_ram, addr, amt,
    input  wr_ready, loaded, pixel_spr_out, pixel_cpr_out
  );

  modport slave (
    input  load_start, wr_valid, wr_data, en_ram, addr, amt,
    output wr_ready, loaded, pixel_spr_out, pixel_cpr_out
  );

endinterface

// File: rtl/me_row_window.sv
// Extracts MACRO_DIM+1 consecutive pixels from one search-window row starting
// at column amt; columns past the right edge read as zero.
//   row   : full SEARCH_DIM-wide row
//   amt   : starting column
//   win_c : combinational window, win_c[i] = row[amt+i] or 0
module me_row_window
  import me_pkg::*;
#(
  parameter int unsigned MACRO_DIM  = MACRO_DIM_DEF,
  parameter int unsigned SEARCH_DIM = SEARCH_DIM_DEF
) (
  input  pixel_t [SEARCH_DIM-1:0] row,
  input  logic   [ADDR_W-1:0]     amt,
  output pixel_t [MACRO_DIM:0]    win_c
);

  localparam int unsigned IDX_W = ADDR_W + 1;
  localparam int unsigned COL_W = $clog2(SEARCH_DIM);

  // Column index kept one bit wider than amt so large offsets never wrap to column 0.
  always_comb begin
    win_c = '0;
    for (int unsigned i = 0; i <= MACRO_DIM; i++) begin
      if (32'(IDX_W'(amt) + IDX_W'(i)) < SEARCH_DIM) begin
        win_c[i] = row[COL_W'(IDX_W'(amt) + IDX_W'(i))];
      end
    end
  end

endmodule

// File: rtl/me_pixel_feeder.sv
// Pixel source for the motion-estimation controller. Loads a search window and
// a current macroblock over a valid/ready beat stream, then serves one
// registered row per en_ram request.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : load stream (load_start/wr_valid/wr_ready/wr_data/loaded) and
//                read port (en_ram/addr/amt -> pixel_spr_out/pixel_cpr_out)
module me_pixel_feeder
  import me_pkg::*;
#(
  parameter int unsigned MACRO_DIM  = MACRO_DIM_DEF,
  parameter int unsigned SEARCH_DIM = SEARCH_DIM_DEF
) (
  input logic               clk,
  input logic               rst_n,
  me_pixel_feeder_if.slave  bus
);

  localparam int unsigned SEGS_L = SEARCH_DIM / MACRO_DIM;
  localparam int unsigned SEG_W  = (SEGS_L > 1) ? $clog2(SEGS_L) : 1;
  localparam int unsigned ROW_W  = $clog2(SEARCH_DIM);
  localparam int unsigned CUR_W  = $clog2(MACRO_DIM);

  feeder_state_t          state_q, state_d;
  logic [SEG_W-1:0]       seg_q, seg_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic                   wr_ready_q, wr_ready_d;
  logic                   loaded_q, loaded_d;
  pixel_t [MACRO_DIM:0]   spr_q, spr_d;
  pixel_t [MACRO_DIM-1:0] cpr_q, cpr_d;

  pixel_t [SEARCH_DIM-1:0] search_q [SEARCH_DIM];
  pixel_t [MACRO_DIM-1:0]  cur_q    [MACRO_DIM];

  logic                   beat_c;
  logic                   spr_we_c;
  logic                   cpr_we_c;
  logic                   rd_row_ok_c;
  logic [ROW_W-1:0]       rd_row_c;
  pixel_t [MACRO_DIM:0]   win_c;

  assign beat_c      = bus.wr_valid && wr_ready_q;
  assign rd_row_ok_c = 32'(bus.addr) < SEARCH_DIM;
  assign rd_row_c    = rd_row_ok_c ? ROW_W'(bus.addr) : '0;

  me_row_window #(
    .MACRO_DIM  (MACRO_DIM),
    .SEARCH_DIM (SEARCH_DIM)
  ) u_row_window (
    .row   (search_q[rd_row_c]),
    .amt   (bus.amt),
    .win_c (win_c)
  );

  // Next state, beat counters, buffer write enables and read-row capture.
  always_comb begin
    state_d  = state_q;
    seg_d    = seg_q;
    row_d    = row_q;
    spr_d    = spr_q;
    cpr_d    = cpr_q;
    spr_we_c = 1'b0;
    cpr_we_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.load_start) begin
          state_d = LOAD_SPR;
          seg_d   = '0;
          row_d   = '0;
        end
      end
      LOAD_SPR: begin
        if (beat_c) begin
          spr_we_c = 1'b1;
          if (seg_q == SEG_W'(SEGS_L - 1)) begin
            seg_d = '0;
            if (row_q == ROW_W'(SEARCH_DIM - 1)) begin
              state_d = LOAD_CPR;
              row_d   = '0;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            seg_d = seg_q + 1'b1;
          end
        end
      end
      LOAD_CPR: begin
        // A load_start coinciding with the last beat is intentionally dropped.
        if (beat_c) begin
          cpr_we_c = 1'b1;
          if (row_q == ROW_W'(MACRO_DIM - 1)) begin
            state_d = SERVE;
            row_d   = '0;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      SERVE: begin
        if (bus.en_ram) begin
          spr_d = rd_row_ok_c ? win_c : '0;
          cpr_d = cur_q[CUR_W'(32'(bus.addr) % MACRO_DIM)];
        end
        if (bus.load_start) begin
          state_d = LOAD_SPR;
          seg_d   = '0;
          row_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ready_d = (state_d == LOAD_SPR) || (state_d == LOAD_CPR);
    loaded_d   = (state_d == SERVE);
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      seg_q      <= '0;
      row_q      <= '0;
      wr_ready_q <= 1'b0;
      loaded_q   <= 1'b0;
      spr_q      <= '0;
      cpr_q      <= '0;
    end else begin
      state_q    <= state_d;
      seg_q      <= seg_d;
      row_q      <= row_d;
      wr_ready_q <= wr_ready_d;
      loaded_q   <= loaded_d;
      spr_q      <= spr_d;
      cpr_q      <= cpr_d;
    end
  end

  // Pixel buffers; contents survive reset.
  always_ff @(posedge clk) begin
    if (rst_n && spr_we_c) begin
      search_q[row_q][32'(seg_q) * MACRO_DIM +: MACRO_DIM] <= bus.wr_data;
    end
    if (rst_n && cpr_we_c) begin
      cur_q[CUR_W'(row_q)] <= bus.wr_data;
    end
  end

  assign bus.wr_ready      = wr_ready_q;
  assign bus.loaded        = loaded_q;
  assign bus.pixel_spr_out = spr_q;
  assign bus.pixel_cpr_out = cpr_q;

endmodule
